// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types and defaults for the frequency meter
//
// Purpose: FSM state encoding, default parameter values and a gate-counter
//          width helper shared by freq_meter and its testbench.
package freq_meter_pkg;

  localparam int DEF_CLK_HZ      = 50_000_000;
  localparam int DEF_GATE_CYCLES = 50_000_000;
  localparam int DEF_CNT_W       = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_GATE = 1'b1
  } fm_state_e;

  // Bits needed to hold GATE_CYCLES-1 (the value loaded into the gate counter).
  function automatic int gate_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with rising-edge detect
//
// Purpose: brings an asynchronous level into the gclk domain and flags
//          each 0->1 transition for exactly one cycle.
// Ports:
//   gclk  in   clock, rising edge
//   rst   in   synchronous active-high reset, clears all flops
//   d     in   asynchronous input level
//   rise  out  high for one cycle per synchronized rising edge
module sync_edge (
  input  logic gclk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync3;

  always_ff @(posedge gclk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // sync1 may be metastable; only the settled stages feed the detector.
  assign rise = sync2 & ~sync3;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge frequency counter
//
// Purpose: on start, opens a window of GATE_CYCLES gclk cycles, counts the
//          rising edges of sig_in seen inside it, then publishes the count
//          on freq with a one-cycle done pulse.
// Ports:
//   gclk    in   clock, rising edge
//   rst     in   synchronous active-high reset
//   sig_in  in   measured signal, asynchronous to gclk
//   start   in   one-cycle request to begin a measurement (ignored while busy)
//   busy    out  high while the gate window is open
//   done    out  one-cycle pulse in the cycle freq/ovf are updated
//   freq    out  edge count of the last completed window
//   ovf     out  edge counter saturated during the last window
// Build option: FREQ_METER_OVF_EN - saturate the edge counter and report ovf;
//               when undefined the counter wraps and ovf is tied low.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CLK_HZ      = DEF_CLK_HZ,
  parameter int GATE_CYCLES = CLK_HZ,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             gclk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] freq,
  output logic             ovf
);

  localparam int            GW        = gate_w(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LOAD = GW'(GATE_CYCLES - 1);

  fm_state_e        state_q, state_d;
  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic [CNT_W-1:0] edge_inc;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             done_q, done_d;
  logic             rise;

`ifdef FREQ_METER_OVF_EN
  logic sat_q, sat_d, sat_inc;
  logic ovf_q, ovf_d;
`endif

  sync_edge u_sync_edge (
    .gclk (gclk),
    .rst  (rst),
    .d    (sig_in),
    .rise (rise)
  );

  // Edge counter value after this cycle's edge is accounted for.
  always_comb begin
`ifdef FREQ_METER_OVF_EN
    edge_inc = edge_q;
    sat_inc  = sat_q;
    if (rise) begin
      if (&edge_q) begin
        sat_inc = 1'b1;
      end else begin
        edge_inc = edge_q + CNT_W'(1);
      end
    end
`else
    edge_inc = edge_q + CNT_W'(rise);
`endif
  end

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    edge_d  = edge_q;
    freq_d  = freq_q;
    done_d  = 1'b0;
`ifdef FREQ_METER_OVF_EN
    sat_d   = sat_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_GATE;
          gate_d  = GATE_LOAD;
          edge_d  = '0;
`ifdef FREQ_METER_OVF_EN
          sat_d   = 1'b0;
`endif
        end
      end
      ST_GATE: begin
        edge_d = edge_inc;
        gate_d = gate_q - GW'(1);
`ifdef FREQ_METER_OVF_EN
        sat_d  = sat_inc;
`endif
        // Last window cycle: its own edge is included in the published count,
        // and the result becomes visible together with done next cycle.
        if (gate_q == '0) begin
          state_d = ST_IDLE;
          gate_d  = '0;
          freq_d  = edge_inc;
          done_d  = 1'b1;
`ifdef FREQ_METER_OVF_EN
          ovf_d   = sat_inc;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gate_q  <= '0;
      edge_q  <= '0;
      freq_q  <= '0;
      done_q  <= 1'b0;
`ifdef FREQ_METER_OVF_EN
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      edge_q  <= edge_d;
      freq_q  <= freq_d;
      done_q  <= done_d;
`ifdef FREQ_METER_OVF_EN
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == ST_GATE);
  assign done = done_q;
  assign freq = freq_q;
`ifdef FREQ_METER_OVF_EN
  assign ovf  = ovf_q;
`else
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - self-checking bench for freq_meter
module tb_freq_meter;

  localparam int GC  = 1000;
  localparam int GC2 = 100;

  logic        gclk = 1'b0;
  logic        rst, sig_in, start, start2;
  logic        busy, done, ovf;
  logic [31:0] freq;
  logic        busy2, done2, ovf2;
  logic [3:0]  freq2;

  always #5 gclk = ~gclk;

  freq_meter #(.CLK_HZ(1000000), .GATE_CYCLES(GC), .CNT_W(32)) dut (
    .gclk(gclk), .rst(rst), .sig_in(sig_in), .start(start),
    .busy(busy), .done(done), .freq(freq), .ovf(ovf)
  );

  freq_meter #(.CLK_HZ(1000000), .GATE_CYCLES(GC2), .CNT_W(4)) dut4 (
    .gclk(gclk), .rst(rst), .sig_in(sig_in), .start(start2),
    .busy(busy2), .done(done2), .freq(freq2), .ovf(ovf2)
  );

  typedef struct {
    int mode;    // 0 low, 1 high, 2 square wave of 'period', 4 random
    int period;
    int pre;     // idle cycles before start
    bit retrig;  // extra start pulses at t+200 and t+500
    int exp;     // fixed expected freq, -1 = model only
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit hist [0:32767];
  longint last_exp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs, remember sig_in, and land 1 time unit past the edge.
  task automatic tick(input bit s, input bit st, input bit st2, input bit r);
    sig_in = s;
    start  = st;
    start2 = st2;
    rst    = r;
    hist[cyc] = s;
    @(posedge gclk);
    #1;
    cyc++;
  endtask

  function automatic bit gen(input int mode, input int period, input int c);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return (c % period) < (period / 2);
      default: return 1'($urandom % 2);
    endcase
  endfunction

  // Reference: input level reaches the detector two cycles late; a window
  // opened by start in cycle t spans cycles t+1..t+g.
  function automatic longint model_count(input int t, input int g);
    longint n = 0;
    for (int m = t + 1; m <= t + g; m++)
      if (hist[m-2] && !hist[m-3]) n++;
    return n;
  endfunction

  task automatic run_window(input vec_t v);
    int t, done_at, busy_bad;
    logic [31:0] f;
    logic o;
    longint n;
    f = '0;
    o = 1'b0;
    for (int i = 0; i < v.pre; i++) tick(gen(v.mode, v.period, cyc), 1'b0, 1'b0, 1'b0);
    t = cyc;
    tick(gen(v.mode, v.period, cyc), 1'b1, 1'b0, 1'b0);
    done_at = -1;
    busy_bad = 0;
    for (int k = 0; k < GC + 10; k++) begin
      if (busy !== ((cyc >= t + 1) && (cyc <= t + GC))) busy_bad++;
      if (done === 1'b1) begin
        done_at = cyc;
        f = freq;
        o = ovf;
        break;
      end
      tick(gen(v.mode, v.period, cyc),
           v.retrig && (cyc == t + 200 || cyc == t + 500), 1'b0, 1'b0);
    end
    if (done_at < 0) begin
      chk("done_timeout", 64'(done_at), 64'(t + GC + 1));
    end else begin
      n = model_count(t, GC);
      last_exp = n;
      chk("done_latency", 64'(done_at - t), 64'(GC + 1));
      chk("freq_model", f, 64'(n));
      if (v.exp >= 0) chk("freq_const", f, 64'(v.exp));
      chk("ovf", o, 0);
      chk("busy_window", 64'(busy_bad), 0);
    end
  endtask

  task automatic run_window4(input int period, input int pre, input int exp_const);
    int t, done_at;
    logic [3:0] f;
    logic o;
    longint n, ef, eo;
    f = '0;
    o = 1'b0;
    for (int i = 0; i < pre; i++) tick(gen(2, period, cyc), 1'b0, 1'b0, 1'b0);
    t = cyc;
    tick(gen(2, period, cyc), 1'b0, 1'b1, 1'b0);
    done_at = -1;
    for (int k = 0; k < GC2 + 10; k++) begin
      if (done2 === 1'b1) begin
        done_at = cyc;
        f = freq2;
        o = ovf2;
        break;
      end
      tick(gen(2, period, cyc), 1'b0, 1'b0, 1'b0);
    end
    if (done_at < 0) begin
      chk("done4_timeout", 64'(done_at), 64'(t + GC2 + 1));
    end else begin
      n = model_count(t, GC2);
`ifdef FREQ_METER_OVF_EN
      ef = (n > 15) ? 15 : n;
      eo = (n > 15) ? 1 : 0;
`else
      ef = n % 16;
      eo = 0;
`endif
      chk("done4_latency", 64'(done_at - t), 64'(GC2 + 1));
      chk("freq4_model", f, 64'(ef));
      chk("freq4_const", f, 64'(exp_const));
      chk("ovf4", o, 64'(eo));
    end
  endtask

  vec_t tbl [8];

  initial begin
    int t, dones, busy_bad;

    tbl[0] = '{mode: 2, period: 10, pre: 5, retrig: 1'b0, exp: 100};
    tbl[1] = '{mode: 0, period: 0,  pre: 5, retrig: 1'b0, exp: 0};
    tbl[2] = '{mode: 1, period: 0,  pre: 5, retrig: 1'b0, exp: 0};
    tbl[3] = '{mode: 2, period: 2,  pre: 5, retrig: 1'b0, exp: 500};
    tbl[4] = '{mode: 2, period: 10, pre: 3, retrig: 1'b1, exp: 100};
    tbl[5] = '{mode: 2, period: 7,  pre: 0, retrig: 1'b0, exp: -1};
    tbl[6] = '{mode: 4, period: 0,  pre: 2, retrig: 1'b0, exp: -1};
    tbl[7] = '{mode: 4, period: 0,  pre: 0, retrig: 1'b0, exp: -1};

    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_freq", freq, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy4", busy2, 0);
    chk("rst_freq4", freq2, 0);

    // Reset mid-window (with start in the same cycle): abort, no done.
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    t = cyc;
    tick(gen(2, 2, cyc), 1'b1, 1'b0, 1'b0);
    while (cyc < t + 400) tick(gen(2, 2, cyc), 1'b0, 1'b0, 1'b0);
    chk("busy_before_rst", busy, 1);
    tick(gen(2, 2, cyc), 1'b1, 1'b0, 1'b1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_freq", freq, 0);
    chk("rst_mid_done", done, 0);
    dones = 0;
    busy_bad = 0;
    for (int i = 0; i < GC + 100; i++) begin
      tick(gen(2, 2, cyc), 1'b0, 1'b0, 1'b0);
      if (done !== 1'b0) dones++;
      if (busy !== 1'b0) busy_bad++;
    end
    chk("rst_no_done", 64'(dones), 0);
    chk("rst_stays_idle", 64'(busy_bad), 0);
    chk("rst_freq_held", freq, 0);

    for (int i = 0; i < 8; i++) run_window(tbl[i]);

    // Freq holds and no stray done while idle with sig_in active.
    dones = 0;
    for (int i = 0; i < 50; i++) begin
      tick(gen(2, 2, cyc), 1'b0, 1'b0, 1'b0);
      if (done !== 1'b0) dones++;
    end
    chk("idle_no_done", 64'(dones), 0);
    chk("idle_freq_hold", freq, 64'(last_exp));
    chk("idle_busy", busy, 0);

    // Narrow counter: 20 edges overflow a 4-bit counter, 10 do not.
`ifdef FREQ_METER_OVF_EN
    run_window4(5, 6, 15);
`else
    run_window4(5, 6, 4);
`endif
    run_window4(10, 0, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, the gclk frequency in Hz, used for documentation and default gate only.
REQ-002 SHALL have parameter GATE_CYCLES, default 50000000, the gate window length in gclk cycles (1 s at default).
REQ-003 SHALL have parameter CNT_W, default 32, the width of the edge counter and the result.
REQ-004 SHALL have port gclk  in  1  the only clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port sig_in  in  1  measured signal, asynchronous to gclk.
REQ-007 SHALL have port start  in  1  one-cycle request to begin a measurement.
REQ-008 SHALL have port busy  out  1  high while a gate window is open.
REQ-009 SHALL have port done  out  1  one-cycle pulse when freq is updated.
REQ-010 SHALL have port freq  out  CNT_W  rising edges of sig_in counted in the last gate window; holds between measurements.
REQ-011 SHALL have port ovf  out  1  edge count saturated in the last window.

Function
REQ-012 SHALL pass sig_in through a 2-flop synchronizer and a third flop; a rising edge is sync2 high with sync3 low, evaluated every cycle.
REQ-013 SHALL implement FSM IDLE -> GATE -> IDLE; no other state is reachable.
REQ-014 SHALL, in IDLE with start high, enter GATE next cycle, load the gate counter with GATE_CYCLES-1, and clear the edge counter.
REQ-015 SHALL ignore start while busy; no restart, no extra done.
REQ-016 SHALL, in GATE, add 1 to the edge counter in every cycle with a detected edge, and decrement the gate counter every cycle.
REQ-017 SHALL, in the GATE cycle where the gate counter is 0, count that cycle's edge, then next cycle write freq, assert done for exactly one cycle, and return to IDLE.
REQ-018 SHALL have latency: start sampled at cycle t gives done at cycle t+1+GATE_CYCLES, with exactly GATE_CYCLES cycles counted.
REQ-019 SHALL drive busy high exactly in GATE cycles.
REQ-020 SHALL ignore edges detected in IDLE.
REQ-021 SHALL accept start in the same cycle done is high; the new window opens next cycle.
REQ-022 SHALL leave freq and ovf unchanged except on the done cycle.

Reset
REQ-023 SHALL, on rst, force state IDLE, busy 0, done 0, freq 0, ovf 0, gate and edge counters 0, and synchronizer flops 0.
REQ-024 SHALL, on rst mid-GATE, abort the window with no done pulse and leave freq at 0.
REQ-025 SHALL take rst priority over start in the same cycle.

Configuration
REQ-026 SHALL, when FREQ_METER_OVF_EN is defined, saturate the edge counter at 2^CNT_W-1 and set ovf on done if saturation occurred in that window.
REQ-027 SHALL, without FREQ_METER_OVF_EN, let the edge counter wrap modulo 2^CNT_W, keep the ovf port, and tie ovf to 0.

Structure
REQ-028 SHALL place the FSM state enum and default constants for CLK_HZ, GATE_CYCLES and CNT_W in shared package freq_meter_pkg.
REQ-029 SHALL put the synchronizer and edge detector in sub-module sync_edge, with ports gclk, rst, d and rise.

Verification (GATE_CYCLES=1000)
REQ-030 SHALL cover: sig_in period 10 cycles, start at t -> done at t+1001, freq=100, ovf=0.
REQ-031 SHALL cover: sig_in held 0 or held 1 from before start -> freq=0.
REQ-032 SHALL cover: sig_in toggling every cycle -> freq=500.
REQ-033 SHALL cover: start pulsed again at t+200 and t+500 -> single done at t+1001, busy continuous.
REQ-034 SHALL cover: rst at t+400 -> busy=0 next cycle, freq=0, no done; a later start measures normally.
REQ-035 SHALL cover: CNT_W=4, 20 edges in window -> with FREQ_METER_OVF_EN, freq=15 and ovf=1; without it, freq=4 and ovf=0.
